ex_mem_flag_stage: RTL and testbench

EX_MEM_FLAG_STAGE -- requirements
Module: ex_mem_flag_stage

---
 rtl/ex_mem_flag_stage_if.sv | 34 +++
 rtl/ex_mem_flag_stage.sv | 67 ++++++
 tb/tb_ex_mem_flag_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ex_mem_flag_stage_if.sv
// EX->MEM stage signal bundle: EX-side instruction fields in, MEM-side registered results and branch decision out.
interface ex_mem_flag_stage_if #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4
);
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic [3:0]        ex_opcode;
  logic [DATA_W-1:0] ex_alu_out;
  logic [2:0]        ex_alu_flags;
  logic [RD_W-1:0]   ex_rd;
  logic              ex_reg_wr;
  logic              ex_br_check;
  logic [2:0]        ex_br_cond;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_out;
  logic [RD_W-1:0]   mem_rd;
  logic              mem_reg_wr;
  logic [2:0]        flags;
  logic              br_taken;

  modport master (
    output stall, flush, ex_valid, ex_opcode, ex_alu_out, ex_alu_flags,
           ex_rd, ex_reg_wr, ex_br_check, ex_br_cond,
    input  mem_valid, mem_alu_out, mem_rd, mem_reg_wr, flags, br_taken
  );

  modport slave (
    input  stall, flush, ex_valid, ex_opcode, ex_alu_out, ex_alu_flags,
           ex_rd, ex_reg_wr, ex_br_check, ex_br_cond,
    output mem_valid, mem_alu_out, mem_rd, mem_reg_wr, flags, br_taken
  );
endinterface

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with architectural {Z,V,N} flag register and combinational branch resolve.
// One cycle EX->MEM latency; stall holds all state, flush (even under stall) inserts a bubble.
module ex_mem_flag_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4
) (
  input logic                clk,
  input logic                rst_n,
  ex_mem_flag_stage_if.slave bus
);
  logic accept;
  logic bubble;
  logic z;
  logic v;
  logic n;
  logic cond;

  assign accept = bus.ex_valid & ~bus.stall & ~bus.flush;
  // Flush overrides stall; an idle EX slot only bubbles when the stage advances.
  assign bubble = bus.flush | (~bus.stall & ~bus.ex_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_valid   <= 1'b0;
      bus.mem_alu_out <= '0;
      bus.mem_rd      <= '0;
      bus.mem_reg_wr  <= 1'b0;
      bus.flags       <= 3'b000;
    end else if (bubble) begin
      bus.mem_valid  <= 1'b0;
      bus.mem_reg_wr <= 1'b0;
    end else if (accept) begin
      bus.mem_valid   <= 1'b1;
      bus.mem_alu_out <= bus.ex_alu_out;
      bus.mem_rd      <= bus.ex_rd;
      bus.mem_reg_wr  <= bus.ex_reg_wr;
      // Only flag-producing opcodes touch the register, so X flags from other ops never land.
      case (bus.ex_opcode)
        4'b0000, 4'b0001:                   bus.flags    <= bus.ex_alu_flags;
        4'b0010, 4'b0100, 4'b0101, 4'b0110: bus.flags[2] <= bus.ex_alu_flags[2];
        default: ;
      endcase
    end
  end

  assign z = bus.flags[2];
  assign v = bus.flags[1];
  assign n = bus.flags[0];

  always_comb begin
    cond = 1'b0;
    case (bus.ex_br_cond)
      3'b000:  cond = ~z;
      3'b001:  cond = z;
      3'b010:  cond = ~z & ~n;
      3'b011:  cond = n;
      3'b100:  cond = z | (~z & ~n);
      3'b101:  cond = n | z;
      3'b110:  cond = v;
      default: cond = 1'b1;
    endcase
  end

  assign bus.br_taken = bus.ex_valid & ~bus.flush & bus.ex_br_check & cond;

  initial begin end
endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Randomized and directed check of ex_mem_flag_stage against a behavioural pipeline/flag model.
module tb_ex_mem_flag_stage;
  localparam int DW = 16;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_mem_flag_stage_if #(.DATA_W(DW), .RD_W(RW)) bus ();
  ex_mem_flag_stage #(.DATA_W(DW), .RD_W(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  logic          m_valid;
  logic [DW-1:0] m_alu;
  logic [RW-1:0] m_rd;
  logic          m_wr;
  logic          m_z, m_v, m_n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_ref(input logic [2:0] c, input logic z, input logic v, input logic n);
    logic r;
    r = 1'b1;
    if (c == 3'd0) r = (z == 1'b0);
    if (c == 3'd1) r = (z == 1'b1);
    if (c == 3'd2) r = (z == 1'b0) && (n == 1'b0);
    if (c == 3'd3) r = (n == 1'b1);
    if (c == 3'd4) r = (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
    if (c == 3'd5) r = (n == 1'b1) || (z == 1'b1);
    if (c == 3'd6) r = (v == 1'b1);
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_alu = '0; m_rd = '0; m_wr = 1'b0;
    m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
  endtask

  task automatic apply(input logic st, input logic fl, input logic vld, input logic [3:0] op,
                       input logic [DW-1:0] alu, input logic [2:0] f, input logic [RW-1:0] rd,
                       input logic wr, input logic bc, input logic [2:0] cnd);
    bus.stall = st; bus.flush = fl; bus.ex_valid = vld; bus.ex_opcode = op;
    bus.ex_alu_out = alu; bus.ex_alu_flags = f; bus.ex_rd = rd; bus.ex_reg_wr = wr;
    bus.ex_br_check = bc; bus.ex_br_cond = cnd;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".valid"}, 32'(bus.mem_valid), 32'(m_valid));
    check_val({tag, ".alu"}, 32'(bus.mem_alu_out), 32'(m_alu));
    check_val({tag, ".rd"}, 32'(bus.mem_rd), 32'(m_rd));
    check_val({tag, ".wr"}, 32'(bus.mem_reg_wr), 32'(m_wr));
    check_val({tag, ".flags"}, 32'(bus.flags), 32'({m_z, m_v, m_n}));
  endtask

  // Inputs are already driven; check the branch decision, advance one edge, update model, check state.
  task automatic cycle(input string tag);
    logic exp_br;
    #1;
    exp_br = bus.ex_valid && !bus.flush && bus.ex_br_check &&
             cond_ref(bus.ex_br_cond, m_z, m_v, m_n);
    check_val({tag, ".br"}, 32'(bus.br_taken), 32'(exp_br));
    @(posedge clk);
    if (bus.flush || (!bus.stall && !bus.ex_valid)) begin
      m_valid = 1'b0;
      m_wr = 1'b0;
    end else if (!bus.stall) begin
      m_valid = 1'b1;
      m_alu = bus.ex_alu_out;
      m_rd = bus.ex_rd;
      m_wr = bus.ex_reg_wr;
      if (bus.ex_opcode inside {4'd0, 4'd1}) {m_z, m_v, m_n} = bus.ex_alu_flags;
      else if (bus.ex_opcode inside {4'd2, 4'd4, 4'd5, 4'd6}) m_z = bus.ex_alu_flags[2];
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] sweep_exp;
    rst_n = 1'b0;
    model_reset();
    apply(0, 0, 0, 4'd0, '0, 3'b000, '0, 0, 0, 3'b000);
    #7;
    check_outputs("reset");
    check_val("reset.br", 32'(bus.br_taken), 32'd0);
    #5 rst_n = 1'b1;

    // SUB Z=1 then BEQ taken, BNE not taken
    apply(0, 0, 1, 4'd1, 16'h0000, 3'b100, 4'd1, 1, 0, 3'b000);
    cycle("sub");
    check_val("sub.flags_const", 32'(bus.flags), 32'b100);
    apply(1, 0, 1, 4'd7, 16'h0, 3'b000, 4'd0, 0, 1, 3'b001);
    #1 check_val("beq.br", 32'(bus.br_taken), 32'd1);
    apply(1, 0, 1, 4'd7, 16'h0, 3'b000, 4'd0, 0, 1, 3'b000);
    #1 check_val("bne.br", 32'(bus.br_taken), 32'd0);
    cycle("bne");

    // ADD flags 011, XOR Z=1 keeps V,N, non-flag op with X flags holds
    apply(0, 0, 1, 4'd0, 16'h0011, 3'b011, 4'd2, 1, 0, 3'b000);
    cycle("add");
    apply(0, 0, 1, 4'd2, 16'h0022, 3'b100, 4'd3, 1, 0, 3'b000);
    cycle("xor");
    check_val("xor.flags_const", 32'(bus.flags), 32'b111);
    apply(0, 0, 1, 4'd7, 16'h0033, 3'bxxx, 4'd4, 0, 0, 3'b000);
    cycle("op7");
    check_val("op7.flags_const", 32'(bus.flags), 32'b111);

    // Accept then stall three cycles with churning inputs
    apply(0, 0, 1, 4'd3, 16'h1234, 3'b000, 4'd5, 1, 0, 3'b000);
    cycle("acc");
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 1, 4'($urandom), 16'($urandom), 3'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 3'($urandom));
      cycle("stall");
      check_val("stall.alu_const", 32'(bus.mem_alu_out), 32'h1234);
      check_val("stall.rd_const", 32'(bus.mem_rd), 32'd5);
      check_val("stall.wr_const", 32'({bus.mem_valid, bus.mem_reg_wr}), 32'b11);
    end

    // Stall and flush together: bubble, flags untouched
    apply(1, 1, 1, 4'd0, 16'hBEEF, 3'b001, 4'd6, 1, 0, 3'b000);
    cycle("stfl");
    check_val("stfl.vw_const", 32'({bus.mem_valid, bus.mem_reg_wr}), 32'b00);
    check_val("stfl.flags_const", 32'(bus.flags), 32'b111);

    // V-only flags and full condition sweep
    apply(0, 0, 1, 4'd0, 16'h0044, 3'b010, 4'd7, 0, 0, 3'b000);
    cycle("addv");
    sweep_exp = 8'b1101_0101;
    for (int c = 0; c < 8; c++) begin
      apply(1, 0, 1, 4'd7, 16'h0, 3'b000, 4'd0, 0, 1, 3'(c));
      #1 check_val($sformatf("sweep%0d", c), 32'(bus.br_taken), 32'(sweep_exp[c]));
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0),
            1'($urandom_range(0, 4) != 0), 4'($urandom), 16'($urandom), 3'($urandom),
            4'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      cycle("rand");
    end

    // Asynchronous reset between edges, during a stall+flush
    apply(1, 1, 1, 4'd0, 16'hFFFF, 3'b111, 4'd9, 1, 0, 3'b000);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("areset");
    apply(0, 0, 1, 4'd0, 16'h0, 3'b000, 4'd0, 0, 0, 3'b000);
    #1 check_val("areset.br", 32'(bus.br_taken), 32'd0);
    #1 rst_n = 1'b1;
    apply(0, 0, 1, 4'd1, 16'h5555, 3'b001, 4'd8, 1, 1, 3'b011);
    cycle("post_rst");
    apply(0, 0, 1, 4'd8, 16'h6666, 3'b000, 4'd9, 1, 1, 3'b011);
    cycle("post_rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
